mx_int_vec_stim_gen: RTL and testbench
======================================

// Module: mx_int_vec_stim_gen
// PURPOSE
//  Synthesizable, parametrised stimulus generator for MX integer ALU blocks (MXINT8 and wider).
//  Builds BLOCK_SIZE-element vectors plus an E8M0 shared scale from a 32-bit LFSR, one element per cycle.
//  Supports random, zero-injection and corner-value modes, and presents each vector on a valid/ready port.
//  Sits in front of the DUT (e.g. negate/add units) in bench and FPGA self-test builds.
// PARAMETERS
//  ELEM_WIDTH   8             element width in bits, two's complement, >=2
//  BLOCK_SIZE   32            elements per vector; power of two, >=2
//  SCALE_WIDTH  8             shared-scale width (E8M0)
//  LFSR_SEED    32'hACE11234  LFSR reset value; a seed of 0 is replaced by 32'h1
//  GAP_CYCLES   32            idle cycles after each accepted vector; 0 allowed
// PORTS
//  clk          in   1                      clock, rising edge
//  rst          in   1                      synchronous, active-high reset
//  start_i      in   1                      start a run; sampled only in IDLE
//  n_vectors_i  in   16                     vectors per run; captured at start
//  mode_i       in   2                      00 random; 01 random + zero at LFSR index; 10 corner; 11 random + zero at zero_idx_i
//  zero_idx_i   in   $clog2(BLOCK_SIZE)     fixed zero index for mode 11; captured at start
//  ready_i      in   1                      consumer accepts the vector
//  elements_o   out  BLOCK_SIZE*ELEM_WIDTH  element i occupies [i*ELEM_WIDTH +: ELEM_WIDTH]
//  scale_o      out  SCALE_WIDTH            shared scale
//  zero_idx_o   out  $clog2(BLOCK_SIZE)     index zeroed in the current vector (modes 01/11)
//  valid_o      out  1                      vector valid
//  busy_o       out  1                      run in progress (state != IDLE)
//  done_o       out  1                      single-cycle pulse at end of run
//  vec_cnt_o    out  16                     vectors accepted in the current run
// BEHAVIOUR
//  - Reset: state=IDLE; LFSR=seed; all outputs 0, including elements_o, scale_o, valid_o and vec_cnt_o.
//  - LFSR: 32-bit Galois, mask 32'h80200003; advances once per GEN cycle, in every mode.
//  - States: IDLE -> GEN -> PRESENT -> GAP -> GEN ... -> DONE -> IDLE.
//  - IDLE: start_i=1 at edge 0 captures the run inputs and clears vec_cnt_o.
//    If n_vectors_i==0, the next state is DONE. Otherwise it is GEN.
//  - GEN, first cycle: scale_o <= LFSR[SCALE_WIDTH-1:0]; 8'hFF (NaN) is forced to 8'hFE.
//    In mode 01, zero_idx_o <= LFSR[$clog2(BLOCK_SIZE)-1:0]. In mode 11, zero_idx_o <= the captured zero_idx_i.
//  - GEN, edge k (1..BLOCK_SIZE) writes element k-1 from LFSR[ELEM_WIDTH-1:0]; the LFSR is replicated if ELEM_WIDTH>32.
//    Modes 01/11: the element at zero_idx_o is written as 0.
//    Mode 10: even indices get +(2^(W-1)-1), odd indices get -2^(W-1).
//  - Edge BLOCK_SIZE: state -> PRESENT and valid_o=1. Latency from start to valid = BLOCK_SIZE edges.
//  - PRESENT: valid_o and all data outputs stay stable until valid_o&&ready_i at an edge.
//    On that edge: vec_cnt_o++ and valid_o=0.
//    Next state is DONE if vec_cnt_o reaches n_vectors; otherwise GAP, or GEN when GAP_CYCLES==0.
//  - ready_i high before valid_o is legal and has no effect; acceptance occurs on the first edge with both high.
//  - GAP: GAP_CYCLES cycles, then GEN.
//  - DONE: done_o=1 for one cycle, then IDLE. elements_o and scale_o hold their last values.
//  - start_i while busy_o=1 is ignored. ready_i outside PRESENT is ignored.
//  - rst mid-run: immediate return to reset state; the LFSR is reseeded and no done_o pulse is produced.
//  - vec_cnt_o is 16 bits; n_vectors_i=16'hFFFF completes without wrap.
// CONFIGURATION
//  - MX_STIM_SYMMETRIC_EN defined: any element value -2^(W-1), including the mode-10 odd slots, is output as -(2^(W-1)-1).
//    The element range becomes symmetric, so negation never overflows.
//  - MX_STIM_SYMMETRIC_EN undefined: raw values pass through and -2^(W-1) can appear.
// TESTING
//  1. Defaults, rst 2 cycles -> all outputs 0. start_i, mode 00, n=1, ready_i tied 1 ->
//     valid_o high after edge 32, accepted on the next edge, done_o pulses once, vec_cnt_o=1.
//  2. Mode 11, zero_idx_i=5, n=3, GAP_CYCLES=32 -> element 5 == 0 in all 3 vectors;
//     valid_o rising edges spaced 1+32+32 cycles apart.
//  3. Mode 01, n=10, ready_i random 30% -> data stable while valid_o&&!ready_i;
//     element[zero_idx_o]==0; scale_o never 8'hFF; exactly 10 acceptances.
//  4. Mode 10, ELEM_WIDTH=8 -> even elements 8'h7F; odd elements 8'h80, or 8'h81 with MX_STIM_SYMMETRIC_EN.
//  5. Mode 00 run with MX_STIM_SYMMETRIC_EN, 1000 vectors -> no element equals 8'h80.
//  6. n=0 -> done_o 1 cycle later, valid_o never set.
//     rst asserted in GEN -> next cycle IDLE, outputs 0; a rerun reproduces the first vector bit-exactly.

Source files
------------

// File: rtl/mx_int_vec_stim_gen.sv
// ---------------------------------------------------------------------------
// mx_int_vec_stim_gen
//
// Stimulus generator for MX integer ALU blocks. Builds BLOCK_SIZE-element
// two's-complement vectors plus an E8M0 shared scale from a 32-bit Galois
// LFSR (one element per cycle) and offers each vector on a valid/ready port.
//
// Optional build macro:
//   MX_STIM_SYMMETRIC_EN - when defined, any element equal to -2^(W-1) is
//                          emitted as -(2^(W-1)-1) so that negating an
//                          element can never overflow.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start_i      in   start a run (sampled only when idle)
//   n_vectors_i  in   vectors per run, captured at start
//   mode_i       in   00 random, 01 random + LFSR-chosen zero,
//                     10 corner values, 11 random + zero at zero_idx_i
//   zero_idx_i   in   fixed zero index for mode 11, captured at start
//   ready_i      in   consumer accepts the presented vector
//   elements_o   out  element i at [i*ELEM_WIDTH +: ELEM_WIDTH]
//   scale_o      out  shared scale (all-ones NaN code never produced)
//   zero_idx_o   out  index zeroed in the current vector (modes 01/11)
//   valid_o      out  vector valid
//   busy_o       out  run in progress
//   done_o       out  one-cycle pulse at end of run
//   vec_cnt_o    out  vectors accepted in the current run
// ---------------------------------------------------------------------------
module mx_int_vec_stim_gen #(
    parameter int          ELEM_WIDTH  = 8,
    parameter int          BLOCK_SIZE  = 32,
    parameter int          SCALE_WIDTH = 8,
    parameter logic [31:0] LFSR_SEED   = 32'hACE11234,
    parameter int          GAP_CYCLES  = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic [15:0]                        n_vectors_i,
    input  logic [1:0]                         mode_i,
    input  logic [$clog2(BLOCK_SIZE)-1:0]      zero_idx_i,
    input  logic                               ready_i,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0]   elements_o,
    output logic [SCALE_WIDTH-1:0]             scale_o,
    output logic [$clog2(BLOCK_SIZE)-1:0]      zero_idx_o,
    output logic                               valid_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [15:0]                        vec_cnt_o
);

    localparam int          IDX_W    = $clog2(BLOCK_SIZE);
    localparam int          REP      = (ELEM_WIDTH + 31) / 32;
    localparam int          GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

    localparam logic [ELEM_WIDTH-1:0]  MOST_NEG = {1'b1, {(ELEM_WIDTH-1){1'b0}}};
    localparam logic [ELEM_WIDTH-1:0]  MOST_POS = ~MOST_NEG;
    localparam logic [ELEM_WIDTH-1:0]  SYM_NEG  = MOST_NEG + ELEM_WIDTH'(1);
    localparam logic [SCALE_WIDTH-1:0] NAN_SUB  = {{(SCALE_WIDTH-1){1'b1}}, 1'b0};

`ifdef MX_STIM_SYMMETRIC_EN
    localparam bit SYMMETRIC = 1'b1;
`else
    localparam bit SYMMETRIC = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_PRESENT,
        ST_GAP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_RAND       = 2'b00,
        MODE_ZERO_LFSR  = 2'b01,
        MODE_CORNER     = 2'b10,
        MODE_ZERO_FIXED = 2'b11
    } mode_e;

    state_e           state;
    mode_e            mode_q;
    logic [15:0]      n_q;
    logic [IDX_W-1:0] zidx_q;
    logic [IDX_W-1:0] elem_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      lfsr;

    logic [31:0]            lfsr_next;
    logic [SCALE_WIDTH-1:0] scale_next;
    logic [IDX_W-1:0]       zidx_first;
    logic [IDX_W-1:0]       zidx_cur;
    logic [ELEM_WIDTH-1:0]  elem_val;
    logic [15:0]            cnt_next;
    logic                   zero_mode;

    // NOTE: every variable gets a default at the top of the always_comb so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
        scale_next = lfsr[SCALE_WIDTH-1:0];
        zidx_first = '0;
        zero_mode  = (mode_q == MODE_ZERO_LFSR) || (mode_q == MODE_ZERO_FIXED);
        cnt_next   = vec_cnt_o + 16'd1;

        if (&scale_next) begin
            scale_next = NAN_SUB;
        end

        if (mode_q == MODE_ZERO_LFSR) begin
            zidx_first = lfsr[IDX_W-1:0];
        end else if (mode_q == MODE_ZERO_FIXED) begin
            zidx_first = zidx_q;
        end

        // Element 0 is written on the same edge that registers the zero
        // index, so it must use the freshly computed index.
        zidx_cur = (elem_idx == '0) ? zidx_first : zero_idx_o;

        elem_val = ELEM_WIDTH'({REP{lfsr}});
        if (mode_q == MODE_CORNER) begin
            elem_val = elem_idx[0] ? MOST_NEG : MOST_POS;
        end
        if (zero_mode && (elem_idx == zidx_cur)) begin
            elem_val = '0;
        end
        if (SYMMETRIC && (elem_val == MOST_NEG)) begin
            elem_val = SYM_NEG;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_RAND;
            n_q        <= '0;
            zidx_q     <= '0;
            elem_idx   <= '0;
            gap_cnt    <= '0;
            lfsr       <= SEED_EFF;
            // NOTE: the element register file is reset too, because the
            // outputs it drives must read zero straight out of reset.
            elements_o <= '0;
            scale_o    <= '0;
            zero_idx_o <= '0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            vec_cnt_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_e'(mode_i);
                        n_q       <= n_vectors_i;
                        zidx_q    <= zero_idx_i;
                        vec_cnt_o <= '0;
                        elem_idx  <= '0;
                        busy_o    <= 1'b1;
                        if (n_vectors_i == 16'd0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= ST_GEN;
                        end
                    end
                end

                ST_GEN: begin
                    lfsr <= lfsr_next;
                    if (elem_idx == '0) begin
                        scale_o    <= scale_next;
                        zero_idx_o <= zidx_first;
                    end
                    elements_o[elem_idx*ELEM_WIDTH +: ELEM_WIDTH] <= elem_val;
                    // BLOCK_SIZE is a power of two, so the index wraps to 0
                    // exactly when the vector is complete.
                    elem_idx <= elem_idx + IDX_W'(1);
                    if (elem_idx == IDX_W'(BLOCK_SIZE - 1)) begin
                        state   <= ST_PRESENT;
                        valid_o <= 1'b1;
                    end
                end

                ST_PRESENT: begin
                    if (ready_i) begin
                        valid_o   <= 1'b0;
                        vec_cnt_o <= cnt_next;
                        if (cnt_next == n_q) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            state <= ST_GEN;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_GEN;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mx_int_vec_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_mx_int_vec_stim_gen
//
// Self-checking bench for mx_int_vec_stim_gen with default parameters.
// A reference LFSR model predicts every vector of a run at start time and
// pushes it to a scoreboard; each accepted vector is popped and compared.
// Honours MX_STIM_SYMMETRIC_EN in the model when defined.
// ---------------------------------------------------------------------------
module tb_mx_int_vec_stim_gen;

    localparam int          W    = 8;
    localparam int          BS   = 32;
    localparam int          SW   = 8;
    localparam int          GAP  = 32;
    localparam int          VW   = W * BS;
    localparam logic [31:0] SEED = 32'hACE11234;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [15:0]   n_vectors_i;
    logic [1:0]    mode_i;
    logic [4:0]    zero_idx_i;
    logic          ready_i;
    logic [VW-1:0] elements_o;
    logic [SW-1:0] scale_o;
    logic [4:0]    zero_idx_o;
    logic          valid_o;
    logic          busy_o;
    logic          done_o;
    logic [15:0]   vec_cnt_o;

    mx_int_vec_stim_gen #(
        .ELEM_WIDTH (W),
        .BLOCK_SIZE (BS),
        .SCALE_WIDTH(SW),
        .LFSR_SEED  (SEED),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .n_vectors_i(n_vectors_i),
        .mode_i     (mode_i),
        .zero_idx_i (zero_idx_i),
        .ready_i    (ready_i),
        .elements_o (elements_o),
        .scale_o    (scale_o),
        .zero_idx_o (zero_idx_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .vec_cnt_o  (vec_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [VW-1:0] elems;
        logic [SW-1:0] scale;
        logic [4:0]    zidx;
    } vec_t;

    vec_t        sb[$];
    logic [31:0] m_lfsr;
    int          rise_q[$];
    int          done_cyc;
    logic [VW-1:0] last_acc_elems;
    logic [VW-1:0] t1_first;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic model_vector(input logic [1:0] mode, input logic [4:0] zcap, output vec_t v);
        logic [W-1:0] e;
        v.zidx  = (mode == 2'b01) ? m_lfsr[4:0] : ((mode == 2'b11) ? zcap : 5'd0);
        v.scale = (m_lfsr[7:0] == 8'hFF) ? 8'hFE : m_lfsr[7:0];
        v.elems = '0;
        for (int k = 0; k < BS; k++) begin
            if (mode == 2'b10) e = (k % 2 == 0) ? 8'h7F : 8'h80;
            else               e = m_lfsr[7:0];
            if ((mode == 2'b01 || mode == 2'b11) && k == int'(v.zidx)) e = 8'h00;
`ifdef MX_STIM_SYMMETRIC_EN
            if (e == 8'h80) e = 8'h81;
`endif
            v.elems[k*W +: W] = e;
            m_lfsr = lfsr_step(m_lfsr);
        end
    endtask

    // Runs one complete run; starts and ends just after a falling edge.
    task automatic run(input logic [1:0] mode, input int n, input logic [4:0] zidx,
                       input int pct, input int budget);
        vec_t v;
        logic prev_valid;
        bit   seen_done;
        int   accepts;
        int   sym_hits;
        rise_q.delete();
        done_cyc = -1;
        for (int i = 0; i < n; i++) begin
            model_vector(mode, zidx, v);
            sb.push_back(v);
        end
        mode_i      = mode;
        n_vectors_i = 16'(n);
        zero_idx_i  = zidx;
        start_i     = 1'b1;
        prev_valid  = 1'b0;
        seen_done   = 1'b0;
        accepts     = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (seen_done) begin
                check("done_one_cycle", VW'(done_o), VW'(0));
                check("busy_after_done", VW'(busy_o), VW'(0));
                break;
            end
            if (valid_o && !prev_valid) rise_q.push_back(cyc);
            if (done_o) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                check("vec_cnt_final", VW'(vec_cnt_o), VW'(n));
                check("valid_in_done", VW'(valid_o), VW'(0));
                check("busy_in_done", VW'(busy_o), VW'(1));
            end
            ready_i = ($urandom_range(99) < pct);
            start_i = seen_done ? 1'b0 : 1'($urandom_range(1));
            if (valid_o) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", VW'(1), VW'(0));
                end else if (!ready_i) begin
                    check("stall_elems", elements_o, sb[0].elems);
                    check("stall_scale", VW'(scale_o), VW'(sb[0].scale));
                end else begin
                    v = sb.pop_front();
                    last_acc_elems = elements_o;
                    check("elems", elements_o, v.elems);
                    check("scale", VW'(scale_o), VW'(v.scale));
                    check("scale_not_nan", VW'(scale_o == 8'hFF), VW'(0));
                    if (mode == 2'b01 || mode == 2'b11) begin
                        check("zero_idx", VW'(zero_idx_o), VW'(v.zidx));
                        check("elem_at_zero_idx", VW'(elements_o[zero_idx_o*W +: W]), VW'(0));
                    end
`ifdef MX_STIM_SYMMETRIC_EN
                    sym_hits = 0;
                    for (int k = 0; k < BS; k++)
                        if (elements_o[k*W +: W] == 8'h80) sym_hits++;
                    check("sym_no_most_neg", VW'(sym_hits), VW'(0));
`endif
                    accepts++;
                end
            end
            prev_valid = valid_o;
        end
        if (!seen_done) check("timeout_no_done", VW'(0), VW'(1));
        start_i = 1'b0;
        ready_i = 1'b0;
        check("accept_count", VW'(accepts), VW'(n));
        check("sb_drained", VW'(sb.size()), VW'(0));
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_elems"}, elements_o, VW'(0));
        check({tag, "_scale"}, VW'(scale_o), VW'(0));
        check({tag, "_zidx"},  VW'(zero_idx_o), VW'(0));
        check({tag, "_valid"}, VW'(valid_o), VW'(0));
        check({tag, "_busy"},  VW'(busy_o), VW'(0));
        check({tag, "_done"},  VW'(done_o), VW'(0));
        check({tag, "_cnt"},   VW'(vec_cnt_o), VW'(0));
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        n_vectors_i = '0;
        mode_i      = '0;
        zero_idx_i  = '0;
        ready_i     = 1'b0;
        m_lfsr      = SEED;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // 1: single random vector, ready always high.
        run(2'b00, 1, 5'd0, 100, 200);
        t1_first = last_acc_elems;
        check("t1_rises", VW'(rise_q.size()), VW'(1));
        if (rise_q.size() == 1) check("t1_latency", VW'(rise_q[0]), VW'(BS + 1));
        check("t1_done_cyc", VW'(done_cyc), VW'(BS + 2));

        // 2: fixed zero index, gap spacing.
        run(2'b11, 3, 5'd5, 100, 400);
        check("t2_rises", VW'(rise_q.size()), VW'(3));
        if (rise_q.size() == 3) begin
            check("t2_spacing_a", VW'(rise_q[1] - rise_q[0]), VW'(1 + GAP + BS));
            check("t2_spacing_b", VW'(rise_q[2] - rise_q[1]), VW'(1 + GAP + BS));
        end

        // 3: LFSR zero index, 30% ready backpressure.
        run(2'b01, 10, 5'd0, 30, 3000);

        // 4: corner values.
        run(2'b10, 2, 5'd0, 100, 300);

        // 5: long random run.
        run(2'b00, 1000, 5'd0, 100, 70000);

        // 6a: zero-length run.
        run(2'b00, 0, 5'd0, 100, 20);
        check("t6_done_cyc", VW'(done_cyc), VW'(1));
        check("t6_no_valid", VW'(rise_q.size()), VW'(0));

        // 6b: reset in the middle of GEN, then rerun from the seed.
        mode_i      = 2'b00;
        n_vectors_i = 16'd1;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_busy_before_rst", VW'(busy_o), VW'(1));
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst    = 1'b0;
        m_lfsr = SEED;
        run(2'b00, 1, 5'd0, 100, 200);
        check("rerun_bitexact", last_acc_elems, t1_first);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
